spi_master_gen2: RTL

SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

---
 rtl/spi_master_gen2_pkg.sv | 23 ++
 rtl/spi_master_gen2_if.sv | 46 ++++
 rtl/spi_master_gen2_clk_gen.sv | 32 +++
 rtl/spi_master_gen2.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spi_master_gen2_pkg.sv
// Shared types for the SPI master: FSM state encoding, latched SPI mode and a
// sizing helper for the chip-select index.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StLead  = 3'd2,
    StTrail = 3'd3,
    StHold  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // A single chip select still needs a one-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_gen2_if.sv
// Host handshake plus SPI pin bundle for spi_master_gen2.
// Optional lsb_first control exists only when SPI_MASTER_LSB_FIRST_EN is defined.
interface spi_master_gen2_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) ();
  import spi_pkg::*;

  localparam int CS_W = sel_width(NUM_CS);

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              cpol;
  logic              cpha;
  logic [CS_W-1:0]   cs_sel;
  logic [DIV_W-1:0]  clk_div;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic [DATA_W-1:0] rx_data;
  logic              tx_ready;
  logic              done;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  start, tx_data, cpol, cpha, cs_sel, clk_div, miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  lsb_first,
`endif
    output rx_data, tx_ready, done, busy, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, cpol, cpha, cs_sel, clk_div, miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
    output lsb_first,
`endif
    input  rx_data, tx_ready, done, busy, sclk, mosi, cs_n
  );

endinterface

// File: rtl/spi_master_gen2_clk_gen.sv
// SCLK half-period timer: down-counter reloaded from the latched divider, with
// a one-cycle tick on the last cycle of every half-period.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign tick = run && (cnt_q == '0);

  // Counting down to zero avoids any overflow for an all-ones divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= load_val;
      cnt_q <= load_val;
    end else if (run) begin
      cnt_q <= tick ? div_q : cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// SPI master, one DATA_W-bit full-duplex word per start, all four SPI modes.
// Define SPI_MASTER_LSB_FIRST_EN to add a per-transfer lsb_first control.
module spi_master_gen2 import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input logic               clk,
  input logic               reset,
  spi_master_gen2_if.master bus
);

  localparam int CS_W  = sel_width(NUM_CS);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q;
  logic [CS_W-1:0]   cs_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [BIT_W-1:0]  bit_q;
  logic              done_q;

  logic              active;
  logic              accept;
  logic              tick;
  logic              last_bit;
  logic              lsb;
  logic              shift_tx;
  logic              sample_rx;
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;

  assign active   = (state_q != StIdle);
  assign accept   = !active && bus.start;
  assign last_bit = (bit_q == LastBit);

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lsb_q <= 1'b0;
    end else if (accept) begin
      lsb_q <= bus.lsb_first;
    end
  end

  assign lsb = lsb_q;
`else
  assign lsb = 1'b0;
`endif

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(bus.clk_div),
    .run     (active),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StSetup;
      StSetup: if (tick) state_d = StLead;
      StLead:  if (tick) state_d = StTrail;
      StTrail: if (tick) state_d = last_bit ? StHold : StLead;
      StHold:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // CPHA=0 launches on the trailing edge and captures on the leading one;
  // CPHA=1 is the mirror image, with the first bit already on the line.
  always_comb begin
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    if (tick) begin
      if (mode_q.cpha) begin
        shift_tx  = (state_q == StLead) && (bit_q != '0);
        sample_rx = (state_q == StTrail);
      end else begin
        shift_tx  = (state_q == StTrail) && !last_bit;
        sample_rx = (state_q == StLead);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= '0;
      cs_q      <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StHold) && tick;
      if (accept) begin
        mode_q  <= {bus.cpol, bus.cpha};
        cs_q    <= bus.cs_sel;
        tx_sh_q <= bus.tx_data;
        rx_sh_q <= '0;
        bit_q   <= '0;
      end else begin
        if (shift_tx) begin
          tx_sh_q <= lsb ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        end
        if (sample_rx) begin
          rx_sh_q <= lsb ? {bus.miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], bus.miso};
        end
        if (tick && (state_q == StTrail) && !last_bit) begin
          bit_q <= bit_q + BIT_W'(1);
        end
        // Only a transfer that reaches the end of HOLD publishes its word.
        if (tick && (state_q == StHold)) begin
          rx_data_q <= rx_sh_q;
        end
      end
    end
  end

  always_comb begin
    sclk = bus.cpol;
    mosi = 1'b0;
    cs_n = '1;
    if (active) begin
      sclk = (state_q == StTrail) ? ~mode_q.cpol : mode_q.cpol;
      mosi = lsb ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
      // An out-of-range index matches no line, so every select stays high.
      for (int i = 0; i < NUM_CS; i++) begin
        cs_n[i] = (cs_q == CS_W'(i)) ? 1'b0 : 1'b1;
      end
    end
  end

  assign bus.sclk     = sclk;
  assign bus.mosi     = mosi;
  assign bus.cs_n     = cs_n;
  assign bus.rx_data  = rx_data_q;
  assign bus.done     = done_q;
  assign bus.tx_ready = !active;
  assign bus.busy     = active;

endmodule
